mem_word_ctrl: RTL and testbench
================================

Name: mem_word_ctrl

Overview:
Multi-cell load/store sequencer placed directly upstream of the byte-wide generic_mem. It accepts one word-level request (1..4 cells, little-endian) from the CPU load/store path over a valid/ready handshake. It then issues one single-cell access per clock on generic_mem's addr/data/we/re bus and returns the assembled read word, or a write completion, over a valid/ready response channel. Out-of-range accesses are flagged and never reach memory.

Parameters:
log2_number_of_cells, 8, log2 of the cell count of the attached generic_mem; used for range checking
addr_size, 32, address and word width in bits
cell_size, 8, bits per memory cell
word_cells, addr_size/cell_size (4), maximum cells per request

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_len  in  2  number of cells minus 1 (0..3)
req_addr  in  addr_size  base cell address
req_wdata  in  addr_size  store data; cell i = bits [i*cell_size +: cell_size]
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  addr_size  load data; cells above len are zero; all zero for stores
rsp_err  out  1  request was out of range and was not performed
mem_addr  out  addr_size  to generic_mem addr_bus
mem_wdata  out  cell_size  to generic_mem data_bus_in
mem_rdata  in  cell_size  from generic_mem data_bus_out (combinational read)
mem_we  out  1  to generic_mem we
mem_re  out  1  to generic_mem re

Behaviour:
- Reset (rst=1 at an edge): state to IDLE, idx=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, latched request cleared. mem_we and mem_re are gated by !rst combinationally, so both are 0 in any cycle where rst=1. Reset mid-operation aborts the request. Cells already written stay written unless generic_mem is also in reset (it then clears itself). No response is produced.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1; mem_we=mem_re=0; mem_addr=0; mem_wdata=0.
  - On req_valid: latch we, len, addr, wdata; set idx=0; clear the rdata register.
  - If the range check fails, go to RESP with err=1. Otherwise go to ACCESS.
- Range check: fails if addr+len >= 2^log2_number_of_cells, computed at addr_size+1 bits so that 32-bit wrap-around is also an error. Memory is never touched on error.
- ACCESS:
  - req_ready=0; mem_addr=addr+idx.
  - Store: mem_we=1, mem_re=0, mem_wdata=wdata cell idx.
  - Load: mem_re=1, mem_we=0, mem_wdata=0, and at the clock edge rdata cell idx <= mem_rdata.
  - If idx==len go to RESP, otherwise idx increments.
  - mem_we and mem_re are never both 1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready go to IDLE and drop rsp_valid.
  - No new request is accepted until the next cycle in IDLE (req_ready=0 in RESP).
- Timing: request accepted at edge T; access cycles T..T+len; rsp_valid first high in the cycle after edge T+len+1. Error path: rsp_valid is high in the cycle after edge T.
- Throughput: the best case is one request per len+3 cycles.
- rsp_rdata: zero for stores and errors; for loads, cells above len are zero (no sign extension).

Decomposition:
- Shared header mem_defs.vh holds the state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the cell_size/word_cells defaults. generic_mem and later memory-side blocks reuse it.
- There is no sub-module. The FSM, idx counter, range comparator and byte-lane mux/demux fit in one module of about 150–250 lines.
- The bench instantiates mem_word_ctrl directly connected to generic_mem.

Test Plan:
- Store len=3, addr=0x10, wdata=0xA1B2C3D4 -> mem_we high for 4 cycles at 0x10..0x13 with data D4,C3,B2,A1; rsp_valid with err=0, rdata=0.
- Load len=3, addr=0x10 after the above -> rsp_rdata=0xA1B2C3D4; load len=1, addr=0x11 -> rsp_rdata=0x0000B2C3.
- Load len=1, addr=0xFF with log2 cells=8 -> rsp_err=1, rdata=0, mem_re never asserted; store len=0, addr=0xFF -> performed, err=0.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stable, req_ready=0; release -> IDLE next cycle, back-to-back request accepted.
- Assert rst during the 2nd cell of a len=3 store to 0x20 -> mem_we=0 in the reset cycle, no rsp_valid, req_ready=1 after reset; a following load of 0x20 (generic_mem also reset) returns 0.
- Request with addr=0xFFFFFFFE, len=3 -> err=1 (wrap detected), no memory access.

Source files
------------

// File: rtl/mem_word_ctrl_pkg.sv
// rtl/mem_word_ctrl_pkg.sv - shared state encoding and cell defaults for the word sequencer
package mem_word_ctrl_pkg;

    localparam int CELL_SIZE_DEF  = 8;
    localparam int WORD_CELLS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_word_ctrl.sv
// rtl/mem_word_ctrl.sv - splits a 1..4 cell word request into single-cell generic_mem accesses
module mem_word_ctrl
    import mem_word_ctrl_pkg::*;
#(
    parameter int log2_number_of_cells = 8,
    parameter int addr_size            = 32,
    parameter int cell_size            = CELL_SIZE_DEF,
    parameter int word_cells           = addr_size / cell_size
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_len,
    input  logic [addr_size-1:0] req_addr,
    input  logic [addr_size-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [addr_size-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [addr_size-1:0] mem_addr,
    output logic [cell_size-1:0] mem_wdata,
    input  logic [cell_size-1:0] mem_rdata,
    output logic                 mem_we,
    output logic                 mem_re
);

    localparam int IDX_W = $clog2(word_cells);

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic                 we_q;
    logic [1:0]           len_q;
    logic [addr_size-1:0] addr_q;
    logic [addr_size-1:0] wdata_q;
    logic [addr_size-1:0] rdata_q;

    // One extra bit so a base address near the top of the 32-bit space cannot wrap past the check.
    logic [addr_size:0] req_end;
    logic [addr_size:0] mem_limit;
    logic               range_fail;

    assign req_end    = {1'b0, req_addr} + (addr_size + 1)'(req_len);
    assign mem_limit  = (addr_size + 1)'(1) << log2_number_of_cells;
    assign range_fail = (req_end >= mem_limit);

    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            len_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        len_q   <= req_len;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        idx     <= '0;
                        rdata_q <= '0;
                        if (range_fail) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            rsp_err <= 1'b0;
                            state   <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!we_q) begin
                        rdata_q[idx*cell_size +: cell_size] <= mem_rdata;
                    end
                    if (idx == IDX_W'(len_q)) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are gated by rst so a reset cycle can never commit a cell.
    always_comb begin
        req_ready = (state == ST_IDLE);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (state == ST_ACCESS) begin
            mem_addr = addr_q + addr_size'(idx);
            if (we_q) begin
                mem_we    = !rst;
                mem_wdata = wdata_q[idx*cell_size +: cell_size];
            end else begin
                mem_re = !rst;
            end
        end
    end

endmodule

// File: tb/tb_mem_word_ctrl.sv
// tb/tb_mem_word_ctrl.sv - scoreboard bench for mem_word_ctrl against a byte-wide memory model
module tb_mem_word_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_len;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_we;
    logic        mem_re;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    rsp_t sb[$];
    wr_t  wq[$];

    logic [7:0] mem_model [256];
    logic [7:0] ref_mem   [256];

    mem_word_ctrl #(
        .log2_number_of_cells(8),
        .addr_size(32),
        .cell_size(8),
        .word_cells(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_len(req_len),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_we(mem_we),
        .mem_re(mem_re)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for generic_mem: combinational read, clears itself on reset.
    assign mem_rdata = mem_model[mem_addr[7:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 8'h00;
        end else if (mem_we) begin
            mem_model[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_req(input logic we, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        logic [32:0] endp;
        logic        err;
        logic [31:0] rd;
        logic [7:0]  a8;
        int          nw, nr, cyc, exp_cyc, exp_nw, exp_nr;
        bit          seen;
        rsp_t        exp;
        rsp_t        got;
        wr_t         w;
        endp = {1'b0, addr} + 33'(len);
        err  = (endp >= 33'd256);
        rd   = '0;
        if (!err) begin
            for (int i = 0; i <= int'(len); i++) begin
                a8 = addr[7:0] + 8'(i);
                if (we) begin
                    wq.push_back({addr + 32'(i), wdata[i*8 +: 8]});
                    ref_mem[a8] = wdata[i*8 +: 8];
                end else begin
                    rd[i*8 +: 8] = ref_mem[a8];
                end
            end
        end
        sb.push_back({err, rd});
        exp_cyc = err ? 1 : int'(len) + 2;
        exp_nw  = (err || !we) ? 0 : int'(len) + 1;
        exp_nr  = (err || we) ? 0 : int'(len) + 1;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle addr=%h got=%b want=1", addr, req_ready);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_len   = len;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;

        nw = 0; nr = 0; cyc = 0; seen = 0;
        while (!seen && cyc < 30) begin
            cyc++;
            if (mem_we === 1'b1 && mem_re === 1'b1) begin
                errors++;
                $display("FAIL we_re_both addr=%h got=11 want=not both", mem_addr);
            end
            if (mem_we === 1'b1) begin
                nw++;
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h want=no write", mem_addr, mem_wdata);
                end else begin
                    w = wq.pop_front();
                    if (mem_addr !== w.a || mem_wdata !== w.d) begin
                        errors++;
                        $display("FAIL write_cell got=%h/%h want=%h/%h", mem_addr, mem_wdata, w.a, w.d);
                    end
                end
            end
            if (mem_re === 1'b1) nr++;
            if (rsp_valid === 1'b1) seen = 1;
            else step();
        end

        exp = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rsp_timeout addr=%h got=no rsp_valid want=rsp_valid", addr);
        end else begin
            got = {rsp_err, rsp_rdata};
            if (got !== exp) begin
                errors++;
                $display("FAIL rsp_data addr=%h len=%0d got err=%b rdata=%h want err=%b rdata=%h",
                         addr, len, got.err, got.rdata, exp.err, exp.rdata);
            end
            checks++;
            if (cyc != exp_cyc) begin
                errors++;
                $display("FAIL rsp_latency addr=%h got=%0d want=%0d", addr, cyc, exp_cyc);
            end
        end
        checks++;
        if (nw != exp_nw || nr != exp_nr) begin
            errors++;
            $display("FAIL access_count addr=%h got we=%0d re=%0d want we=%0d re=%0d",
                     addr, nw, nr, exp_nw, exp_nr);
        end

        for (int h = 0; h < hold; h++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || {rsp_err, rsp_rdata} !== exp || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL rsp_hold cycle=%0d got valid=%b err=%b rdata=%h rdy=%b want 1/%b/%h/0",
                         h, rsp_valid, rsp_err, rsp_rdata, req_ready, exp.err, exp.rdata);
            end
        end

        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_release got valid=%b rdy=%b want valid=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
            mem_we !== 1'b0 || mem_re !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got valid=%b err=%b rdata=%h we=%b re=%b rdy=%b want 0/0/0/0/0/1",
                     rsp_valid, rsp_err, rsp_rdata, mem_we, mem_re, req_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_store;
        do_req(1'b1, 2'd3, 32'h10, 32'hA1B2C3D4, 0);
    endtask

    task automatic test_load;
        do_req(1'b0, 2'd3, 32'h10, 32'h0, 0);
        do_req(1'b0, 2'd1, 32'h11, 32'h0, 0);
    endtask

    task automatic test_range;
        do_req(1'b0, 2'd1, 32'hFF, 32'h0, 0);
        do_req(1'b1, 2'd0, 32'hFF, 32'h0000005A, 0);
        do_req(1'b0, 2'd0, 32'hFF, 32'h0, 0);
    endtask

    task automatic test_back_to_back;
        do_req(1'b0, 2'd3, 32'h10, 32'h0, 5);
        do_req(1'b0, 2'd0, 32'h12, 32'h0, 0);
        do_req(1'b1, 2'd2, 32'h40, 32'h00112233, 0);
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_len   = 2'd3;
        req_addr  = 32'h20;
        req_wdata = 32'h55667788;
        step();
        req_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h20) begin
            errors++;
            $display("FAIL mid_first_cell got we=%b addr=%h want we=1 addr=00000020", mem_we, mem_addr);
        end
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_gate got we=%b re=%b want 0/0", mem_we, mem_re);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_after_reset cycle=%0d got valid=%b rdy=%b want 0/1", c, rsp_valid, req_ready);
            end
            step();
        end
        do_req(1'b0, 2'd3, 32'h20, 32'h0, 0);
    endtask

    task automatic test_wrap;
        do_req(1'b0, 2'd3, 32'hFFFFFFFE, 32'h0, 0);
        do_req(1'b1, 2'd3, 32'hFFFFFFFE, 32'hDEADBEEF, 0);
        do_req(1'b0, 2'd0, 32'h100, 32'h0, 0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 12; n++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   32'($urandom_range(0, 270)), $urandom, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_len   = 2'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_store();
        test_load();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
